// File: rtl/jtl_pulse_array.sv
// Multi-channel toggle-encoded pulse transport with fixed latency, per-channel
// minimum-gap policing, sticky violation flags and delivered-pulse counters.
module jtl_pulse_array #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned MIN_GAP  = 2,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       a,
   input  logic [CHANNELS-1:0]       en,
   input  logic                      viol_clr,
   output logic [CHANNELS-1:0]       q,
   output logic [CHANNELS-1:0]       viol,
   output logic [CHANNELS*CNT_W-1:0] pulse_cnt
);

   localparam int unsigned GapW = $clog2(MIN_GAP + 1);
   localparam logic [GapW-1:0] GapMax = GapW'(MIN_GAP);

   // First edge after reset only captures a; nothing is detected on it.
   logic armed_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic             a_prev_q;
      logic [GapW-1:0]  gap_q, gap_d;
      logic [DEPTH-1:0] pipe_q, pipe_d;
      logic             q_q, q_d;
      logic             viol_q, viol_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             det, gap_ok, accept, deliver;

      always_comb begin
         det     = armed_q && (a[i] != a_prev_q);
         gap_ok  = (gap_q == GapMax);
         accept  = det && en[i] && gap_ok;
         deliver = pipe_q[DEPTH-1];

         gap_d = gap_q;
         if (accept) begin
            gap_d = GapW'(1);
         end else if (!gap_ok) begin
            gap_d = gap_q + GapW'(1);
         end

         pipe_d = (pipe_q << 1) | DEPTH'(accept);
         q_d    = q_q ^ deliver;
         cnt_d  = deliver ? cnt_q + CNT_W'(1) : cnt_q;
         // A new violation wins over a simultaneous clear.
         viol_d = (viol_q && !viol_clr) || (det && en[i] && !gap_ok);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_prev_q <= 1'b0;
            gap_q    <= GapMax;
            pipe_q   <= '0;
            q_q      <= 1'b0;
            viol_q   <= 1'b0;
            cnt_q    <= '0;
         end else begin
            a_prev_q <= a[i];
            gap_q    <= gap_d;
            pipe_q   <= pipe_d;
            q_q      <= q_d;
            viol_q   <= viol_d;
            cnt_q    <= cnt_d;
         end
      end

      assign q[i]                         = q_q;
      assign viol[i]                      = viol_q;
      assign pulse_cnt[i*CNT_W +: CNT_W]  = cnt_q;
   end

endmodule
